// File: rtl/stopwatch_ctrl.sv
`timescale 1ns/1ps
// stopwatch_ctrl: button sync/debounce and IDLE/RUN/LAP/STOP sequencer.
// Build option AUTO_STOP_EN: freeze at 59:59.99 instead of wrapping.
module stopwatch_ctrl #(
  parameter int DEB_CYCLES  = 20,
  parameter int LONG_CYCLES = 1500
) (
  input  logic       new_clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap_clear,
  input  logic       max_reached,
  output logic       run_en,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic       lap_capture,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_LAP  = 2'b10,
    S_STOP = 2'b11
  } state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic [1:0] btn;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] deb;
  logic [1:0] deb_d;
  logic [1:0] press;
  logic [7:0] cnt [2];
  state_t     cur;
  state_t     nxt;
  logic       ss_ev;
  logic       lc_ev;
  logic       at_max;

  // bit 0 = start_stop, bit 1 = lap_clear; both active-low
  assign btn   = {lap_clear, start_stop};
  assign ss_ev = press[0];
  assign lc_ev = press[1];

`ifdef AUTO_STOP_EN
  assign at_max = max_reached;
  logic unused_cfg;
  assign unused_cfg = ^LONG_CYCLES;
`else
  assign at_max = 1'b0;
  logic unused_cfg;
  assign unused_cfg = max_reached ^ (^LONG_CYCLES);
`endif

  // Synchronize, debounce and turn each debounced fall into one pulse
  always_ff @(posedge new_clk or negedge rst) begin
    if (!rst) begin
      sync1  <= '1;
      sync2  <= '1;
      deb    <= '1;
      deb_d  <= '1;
      press  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb_d & ~deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  // Next state from press events; start_stop outranks lap_clear
  always_comb begin
    nxt = cur;
    unique case (cur)
      S_IDLE: begin
        if (ss_ev) nxt = S_RUN;
      end
      S_RUN: begin
        if (ss_ev)      nxt = S_STOP;
        else if (lc_ev) nxt = S_LAP;
      end
      S_LAP: begin
        if (ss_ev)      nxt = S_STOP;
        else if (lc_ev) nxt = S_RUN;
      end
      S_STOP: begin
        if (ss_ev && !at_max) nxt = S_RUN;
        else if (lc_ev)       nxt = S_IDLE;
      end
    endcase
    if (at_max && (cur == S_RUN || cur == S_LAP))
      nxt = S_STOP;
  end

  // State register with outputs registered from the next state
  always_ff @(posedge new_clk or negedge rst) begin
    if (!rst) begin
      cur         <= S_IDLE;
      run_en      <= 1'b0;
      cnt_clr     <= 1'b1;
      disp_hold   <= 1'b0;
      lap_capture <= 1'b0;
    end else begin
      cur         <= nxt;
      run_en      <= (nxt == S_RUN) || (nxt == S_LAP);
      cnt_clr     <= (nxt == S_IDLE);
      disp_hold   <= (nxt == S_LAP);
      lap_capture <= (cur == S_RUN) && (nxt == S_LAP);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
`timescale 1ns/1ps
// tb_stopwatch_ctrl: scoreboard bench for the stopwatch control FSM.
// Expected output words are queued per cycle and checked at negedge.
module tb_stopwatch_ctrl;

  localparam int D = 4;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] LAP  = 2'b10;
  localparam logic [1:0] STOP = 2'b11;

  logic       new_clk     = 1'b0;
  logic       rst         = 1'b1;
  logic       start_stop  = 1'b1;
  logic       lap_clear   = 1'b1;
  logic       max_reached = 1'b0;
  logic       run_en;
  logic       cnt_clr;
  logic       disp_hold;
  logic       lap_capture;
  logic [1:0] state;

  typedef struct {
    int         cyc;
    logic [5:0] exp;
    string      tag;
  } item_t;

  item_t      sbq[$];
  int         edge_n = 0;
  int         n_cmp  = 0;
  int         n_bad  = 0;
  logic [1:0] m_state = IDLE;
  logic [5:0] obs;

  stopwatch_ctrl #(.DEB_CYCLES(D)) dut (
    .new_clk     (new_clk),
    .rst         (rst),
    .start_stop  (start_stop),
    .lap_clear   (lap_clear),
    .max_reached (max_reached),
    .run_en      (run_en),
    .cnt_clr     (cnt_clr),
    .disp_hold   (disp_hold),
    .lap_capture (lap_capture),
    .state       (state)
  );

  always #5 new_clk = ~new_clk;

  always @(posedge new_clk) edge_n <= edge_n + 1;

  assign obs = {state, run_en, cnt_clr, disp_hold, lap_capture};

  task automatic chk(string tag, logic [5:0] got, logic [5:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)",
               tag, got, exp, edge_n);
    end
  endtask

  function automatic logic [5:0] outs_of(logic [1:0] st, logic cap);
    return {st, (st == RUN) || (st == LAP), st == IDLE, st == LAP, cap};
  endfunction

  function automatic logic [1:0] spec_next(logic [1:0] st,
                                           bit ss, bit lc, bit mx);
    if (mx && (st == RUN || st == LAP)) return STOP;
    case (st)
      IDLE:    return ss ? RUN : IDLE;
      RUN:     return ss ? STOP : (lc ? LAP : RUN);
      LAP:     return ss ? STOP : (lc ? RUN : LAP);
      default: return (ss && !mx) ? RUN : (lc ? IDLE : STOP);
    endcase
  endfunction

  task automatic expect_at(int cyc, logic [5:0] v, string tag);
    item_t it;
    it.cyc = cyc;
    it.exp = v;
    it.tag = tag;
    sbq.push_back(it);
  endtask

  always @(negedge new_clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= edge_n) begin
      item_t it;
      it = sbq.pop_front();
      chk(it.tag, obs, it.exp);
    end
  end

  // Clean press: buttons low from the negedge after edge k, so the first
  // sampling edge is k+1 and the state change lands on k+1+D+3.
  task automatic press(bit ss, bit lc, int low, string tag);
    logic [1:0] nx;
    logic       cap;
    int         k;
    @(negedge new_clk);
    k   = edge_n;
    nx  = spec_next(m_state, ss, lc, max_reached);
    cap = (m_state == RUN) && (nx == LAP);
    expect_at(k + D + 3, outs_of(m_state, 1'b0), {tag, "_pre"});
    expect_at(k + D + 4, outs_of(nx, cap), tag);
    expect_at(k + D + 5, outs_of(nx, 1'b0), {tag, "_post"});
    expect_at(k + D + 9, outs_of(nx, 1'b0), {tag, "_hold"});
    if (ss) start_stop = 1'b0;
    if (lc) lap_clear = 1'b0;
    repeat (low) @(negedge new_clk);
    start_stop = 1'b1;
    lap_clear  = 1'b1;
    m_state    = nx;
    repeat (D + 6) @(negedge new_clk);
  endtask

  task automatic glitch(int low, string tag);
    int k;
    @(negedge new_clk);
    k = edge_n;
    expect_at(k + D + 4, outs_of(m_state, 1'b0), tag);
    expect_at(k + D + 8, outs_of(m_state, 1'b0), {tag, "_late"});
    start_stop = 1'b0;
    repeat (low) @(negedge new_clk);
    start_stop = 1'b1;
    repeat (D + 8) @(negedge new_clk);
  endtask

  initial begin
    int k;
    rst = 1'b0;
    repeat (3) @(negedge new_clk);
    chk("reset_state", obs, outs_of(IDLE, 1'b0));
    rst = 1'b1;
    k = edge_n;
    for (int i = 1; i <= 50; i++)
      expect_at(k + i, outs_of(IDLE, 1'b0), "idle_quiet");
    repeat (52) @(negedge new_clk);

    glitch(3, "glitch3");
    glitch(D - 1, "glitch_max");

    for (int t = 0; t < 2; t++) begin
      start_stop = 1'b0;
      repeat (2) @(negedge new_clk);
      start_stop = 1'b1;
      repeat (2) @(negedge new_clk);
    end
    press(1'b1, 1'b0, 10, "bounce_start");

    press(1'b0, 1'b1, 10, "run_lap");
    press(1'b0, 1'b1, 10, "lap_run");
    press(1'b1, 1'b1, 10, "run_both_stop");
    press(1'b0, 1'b1, 10, "stop_clear");
    press(1'b0, 1'b1, 10, "idle_lc_stay");
    press(1'b1, 1'b0, 10, "idle_run");
    press(1'b1, 1'b0, 10, "run_stop");
    press(1'b1, 1'b0, 10, "stop_run");
    press(1'b0, 1'b1, 10, "run_lap2");
    press(1'b1, 1'b0, 10, "lap_stop");
    press(1'b1, 1'b0, 10, "stop_run2");
    press(1'b0, 1'b1, 10, "run_lap3");

    @(negedge new_clk);
    lap_clear = 1'b0;
    repeat (3) @(negedge new_clk);
    #2 rst = 1'b0;
    #1 chk("async_reset", obs, outs_of(IDLE, 1'b0));
    lap_clear = 1'b1;
    m_state   = IDLE;
    @(negedge new_clk);
    rst = 1'b1;
    k = edge_n;
    expect_at(k + 2, outs_of(IDLE, 1'b0), "post_rst_a");
    expect_at(k + D + 5, outs_of(IDLE, 1'b0), "post_rst_b");
    expect_at(k + D + 10, outs_of(IDLE, 1'b0), "post_rst_c");
    repeat (D + 12) @(negedge new_clk);

`ifdef AUTO_STOP_EN
    press(1'b1, 1'b0, 10, "auto_run");
    @(negedge new_clk);
    max_reached = 1'b1;
    k = edge_n;
    expect_at(k + 1, outs_of(STOP, 1'b0), "auto_stop");
    m_state = STOP;
    repeat (2) @(negedge new_clk);
    press(1'b1, 1'b0, 10, "auto_ss_ignored");
    press(1'b0, 1'b1, 10, "auto_clear");
    max_reached = 1'b0;
`endif

    for (int w = 0; w < 100 && sbq.size() > 0; w++)
      @(negedge new_clk);
    chk("sb_drained", 6'(sbq.size()), 6'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
